fetch_stage: RTL and testbench

Instruction-fetch stage that sits directly upstream of the decode/control unit. It owns the PC and issues requests to a variable-latency instruction memory. It absorbs redirects from execute, halts, and decode stalls, and drives the IF/ID pipeline register that decode consumes. Decode sees either a valid instruction with its PC+2, or a NOP bubble.

---
 rtl/fetch_stage.sv | 173 +++++++++++++++++
 tb/tb_fetch_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives a variable-latency instruction
// memory, and fills the IF/ID register with instructions or NOP bubbles.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   imem_en, imem_addr          fetch request and its address
//   imem_data, imem_done        returned instruction and its valid
//   stall, redirect, halt       decode hold, taken branch, HALT in ID
//   redirect_pc                 branch/jump target
//   if_id_instr, if_id_pc_inc   IF/ID instruction and its fetch PC + 2
//   if_id_valid                 IF/ID holds a real instruction
//   pc, halted                  next fetch address, frozen indicator
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_inc,
  output logic        if_id_valid,
  output logic [15:0] pc,
  output logic        halted
);

  localparam logic [15:0] NOP = 16'h0800;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DRAIN,
    HALTED
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [15:0] req_addr;
  logic [15:0] req_n;
  logic [15:0] pc_n;
  logic [15:0] instr_n;
  logic [15:0] inc_n;
  logic        valid_n;
  logic        pend;
  logic        pend_n;
  logic [15:0] pc_plus2;
  logic [15:0] req_plus2;

  assign pc_plus2  = pc + 16'd2;
  assign req_plus2 = req_addr + 16'd2;

  // Memory-side outputs depend on registered state only.
  assign imem_en   = (state != HALTED);
  assign imem_addr = (state == WAIT || state == DRAIN)
                   ? req_addr : pc;
  assign halted    = (state == HALTED);

  always_comb begin
    state_n = state;
    req_n   = req_addr;
    pc_n    = pc;
    instr_n = if_id_instr;
    inc_n   = if_id_pc_inc;
    valid_n = if_id_valid;
    pend_n  = pend;
    unique case (state)
      FETCH: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          instr_n = NOP;
          valid_n = 1'b0;
          // Data returning with the redirect is simply dropped.
          if (!imem_done) begin
            req_n   = pc;
            state_n = DRAIN;
          end
        end else if (halt) begin
          instr_n = NOP;
          valid_n = 1'b0;
          if (imem_done) begin
            state_n = HALTED;
          end else begin
            pend_n  = 1'b1;
            req_n   = pc;
            state_n = DRAIN;
          end
        end else if (imem_done) begin
          // Under stall the word is dropped and refetched later.
          if (!stall) begin
            instr_n = imem_data;
            inc_n   = pc_plus2;
            valid_n = 1'b1;
            pc_n    = pc_plus2;
          end
        end else begin
          req_n   = pc;
          state_n = WAIT;
          if (!stall) begin
            instr_n = NOP;
            valid_n = 1'b0;
          end
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          instr_n = NOP;
          valid_n = 1'b0;
          state_n = imem_done ? FETCH : DRAIN;
        end else if (halt) begin
          pend_n  = 1'b1;
          instr_n = NOP;
          valid_n = 1'b0;
          state_n = DRAIN;
        end else if (imem_done) begin
          if (!stall) begin
            instr_n = imem_data;
            inc_n   = req_plus2;
            valid_n = 1'b1;
            pc_n    = req_plus2;
          end
          state_n = FETCH;
        end else if (!stall) begin
          instr_n = NOP;
          valid_n = 1'b0;
        end
      end
      DRAIN: begin
        instr_n = NOP;
        valid_n = 1'b0;
        if (redirect) begin
          pc_n = redirect_pc;
        end else if (halt) begin
          pend_n = 1'b1;
        end
        if (imem_done) begin
          state_n = pend_n ? HALTED : FETCH;
        end
      end
      HALTED: begin
        state_n = HALTED;
      end
      default: begin
        state_n = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= 16'h0000;
      req_addr     <= 16'h0000;
      pend         <= 1'b0;
      if_id_instr  <= NOP;
      if_id_pc_inc <= 16'h0000;
      if_id_valid  <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      req_addr     <= req_n;
      pend         <= pend_n;
      if_id_instr  <= instr_n;
      if_id_pc_inc <= inc_n;
      if_id_valid  <= valid_n;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory model returns 16'hC000+addr,
// a scoreboard queue holds the instructions expected in IF/ID.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_done;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_inc;
  logic        if_id_valid;
  logic [15:0] pc;
  logic        halted;

  int checks;
  int errors;
  logic [31:0] sb[$];

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .imem_done   (imem_done),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .if_id_instr (if_id_instr),
    .if_id_pc_inc(if_id_pc_inc),
    .if_id_valid (if_id_valid),
    .pc          (pc),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_data = 16'hC000 + imem_addr;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // kind: 0 expect bubble, 1 expect instruction at ea, 2 no IF/ID check
  task automatic step(input logic d, input logic st,
                      input logic rd, input logic [15:0] rpc,
                      input logic h, input int kind,
                      input logic [15:0] ea);
    logic [31:0] e;
    imem_done   = d;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    halt        = h;
    if (kind == 1) sb.push_back({16'hC000 + ea, ea + 16'd2});
    @(posedge clk);
    #1;
    if (kind == 1) begin
      chk("valid", {15'd0, if_id_valid}, 16'd1);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
        e = sb.pop_front();
        chk("instr", if_id_instr, e[31:16]);
        chk("pc_inc", if_id_pc_inc, e[15:0]);
      end
    end else if (kind == 0) begin
      chk("bub_valid", {15'd0, if_id_valid}, 16'd0);
      chk("bub_instr", if_id_instr, 16'h0800);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_done = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0;
    halt = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    do_reset();

    chk("rst_pc", pc, 16'h0000);
    chk("rst_valid", {15'd0, if_id_valid}, 16'd0);
    chk("rst_instr", if_id_instr, 16'h0800);
    chk("rst_inc", if_id_pc_inc, 16'h0000);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_en", {15'd0, imem_en}, 16'd1);
    chk("rst_addr", imem_addr, 16'h0000);

    for (int i = 0; i < 5; i++) begin
      chk("seq_addr", imem_addr, 16'(2 * i));
      step(1, 0, 0, 0, 0, 1, 16'(2 * i));
    end
    chk("seq_pc", pc, 16'h000A);

    step(0, 0, 0, 0, 0, 0, 0);
    chk("w2_addr", imem_addr, 16'h000A);
    chk("w2_pc", pc, 16'h000A);
    step(1, 0, 0, 0, 0, 1, 16'h000A);
    chk("w2_pc1", pc, 16'h000C);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("w2_addr2", imem_addr, 16'h000C);
    step(1, 0, 0, 0, 0, 1, 16'h000C);
    chk("w2_pc2", pc, 16'h000E);

    step(1, 0, 0, 0, 0, 1, 16'h000E);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 0, 2, 0);
      chk("st_pc", pc, 16'h0010);
      chk("st_instr", if_id_instr, 16'hC00E);
      chk("st_inc", if_id_pc_inc, 16'h0010);
      chk("st_valid", {15'd0, if_id_valid}, 16'd1);
    end
    step(1, 0, 0, 0, 0, 1, 16'h0010);

    for (int i = 0; i < 7; i++) begin
      step(1, 0, 0, 0, 0, 1, 16'(16'h0012 + 2 * i));
    end
    chk("rw_pc", pc, 16'h0020);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rw_wait_addr", imem_addr, 16'h0020);
    step(0, 0, 1, 16'h0100, 0, 0, 0);
    chk("rw_drain_addr", imem_addr, 16'h0020);
    chk("rw_pc", pc, 16'h0100);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rw_new_addr", imem_addr, 16'h0100);
    step(1, 0, 0, 0, 0, 1, 16'h0100);
    chk("rw_pc2", pc, 16'h0102);

    step(1, 0, 0, 0, 1, 0, 0);
    chk("hf_halted", {15'd0, halted}, 16'd1);
    chk("hf_en", {15'd0, imem_en}, 16'd0);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      chk("hf_pc", pc, 16'h0102);
      chk("hf_halted", {15'd0, halted}, 16'd1);
      chk("hf_en", {15'd0, imem_en}, 16'd0);
    end
    do_reset();
    chk("hr_pc", pc, 16'h0000);
    chk("hr_halted", {15'd0, halted}, 16'd0);
    chk("hr_en", {15'd0, imem_en}, 16'd1);

    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("hw_halted0", {15'd0, halted}, 16'd0);
    chk("hw_en", {15'd0, imem_en}, 16'd1);
    chk("hw_addr", imem_addr, 16'h0000);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("hw_halted1", {15'd0, halted}, 16'd0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("hw_halted2", {15'd0, halted}, 16'd1);
    chk("hw_pc", pc, 16'h0000);
    do_reset();

    step(0, 0, 1, 16'h0200, 0, 0, 0);
    chk("rf_drain_addr", imem_addr, 16'h0000);
    chk("rf_pc", pc, 16'h0200);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rf_addr", imem_addr, 16'h0200);

    step(1, 1, 1, 16'hFFFE, 1, 0, 0);
    chk("sim_halted", {15'd0, halted}, 16'd0);
    chk("sim_pc", pc, 16'hFFFE);
    chk("sim_addr", imem_addr, 16'hFFFE);
    step(1, 0, 0, 0, 0, 1, 16'hFFFE);
    chk("wrap_pc", pc, 16'h0000);

    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
